// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo: show-ahead byte FIFO between a UART receiver and its consumer.
// Writes come from a single-cycle strobe with no backpressure; a byte that
// arrives while the FIFO is full and not draining is dropped.
// Optional feature: define RX_FIFO_OVERFLOW_EN to build a sticky lost-byte
// flag on o_overflow; without it o_overflow is tied to 0.
module rx_byte_fifo #(
  parameter int DEPTH = 8  // power of two, 2..64
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [7:0]               i_data,
  input  logic                     i_valid,
  input  logic                     i_clr,
  output logic [7:0]               o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  // Decide this cycle's pop and push from registered occupancy only.
  // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_empty = 1'b0;
    w_full  = 1'b0;
    w_pop   = 1'b0;
    w_push  = 1'b0;
    w_empty = (r_count == '0);
    w_full  = (r_count == CW'(DEPTH));
    // Ready is meaningless while the FIFO is empty.
    w_pop   = !w_empty && i_ready;
    // A full FIFO still accepts a byte when the head leaves the same cycle.
    w_push  = i_valid && (!w_full || w_pop);
  end

  // Byte storage: written at the write pointer on every accepted push.
  // NOTE: the array has no reset; pointers and count define which entries are live, so stale contents are harmless.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_clr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy; flush overrides any push or pop on the same edge.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef RX_FIFO_OVERFLOW_EN
  logic w_drop;
  logic r_overflow;

  // A drop is a strobe that arrives while full with no pop to make room.
  assign w_drop = i_valid && w_full && !w_pop;

  // Sticky lost-byte flag, cleared only by flush or reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow <= 1'b0;
    end else if (i_clr) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign o_overflow = r_overflow;
`else
  assign o_overflow = 1'b0;
`endif

  // Show-ahead head: the entry under the read pointer, no output register.
  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = !w_empty;
  assign o_full  = w_full;
  assign o_count = r_count;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Self-checking bench for rx_byte_fifo (DEPTH=8). The reference model is a
// byte queue: its size is the expected occupancy and its front the expected
// head. A driver issues one cycle of stimulus at a time and appends accepted
// bytes; a monitor compares status every cycle and pops/compares the head
// whenever the DUT hands a byte to the consumer.
module tb_rx_byte_fifo;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          i_clk;
  logic          i_rst_n;
  logic [7:0]    i_data;
  logic          i_valid;
  logic          i_clr;
  logic [7:0]    o_data;
  logic          o_valid;
  logic          i_ready;
  logic [CW-1:0] o_count;
  logic          o_full;
  logic          o_overflow;

  rx_byte_fifo #(.DEPTH(DEPTH)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .i_clr      (i_clr),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_count    (o_count),
    .o_full     (o_full),
    .o_overflow (o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model state.
  logic [7:0] exp_q[$];
  bit         m_ovf;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit exp_ovf();
`ifdef RX_FIFO_OVERFLOW_EN
    return m_ovf;
`else
    return 1'b0;
`endif
  endfunction

  // One clock of stimulus: drive after the falling edge, predict what the
  // rising edge does from the model alone, and apply it just after that edge.
  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic c);
    int sz;
    bit pop, acc;
    @(negedge i_clk);
    #1;
    i_valid = v;
    i_data  = d;
    i_ready = r;
    i_clr   = c;
    sz  = exp_q.size();
    pop = (sz > 0) && r;
    acc = v && ((sz < DEPTH) || pop);
    @(posedge i_clk);
    #1;
    if (c) begin
      exp_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (acc) exp_q.push_back(d);
      if (v && !acc) m_ovf = 1'b1;
    end
  endtask

  // Monitor: mid-cycle, with inputs and state both stable.
  initial begin
    forever begin
      @(negedge i_clk);
      #3;
      check("count", 32'(o_count), 32'(exp_q.size()));
      check("valid", 32'(o_valid), 32'(exp_q.size() != 0));
      check("full",  32'(o_full),  32'(exp_q.size() == DEPTH));
      check("ovf",   32'(o_overflow), 32'(exp_ovf()));
      if (o_valid && i_ready && i_rst_n && !i_clr) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 32'(o_data), 32'hFFFF_FFFF);
        end else begin
          check("pop_data", 32'(o_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [7:0] last_in;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_data  = 8'h00;
    i_ready = 1'b0;
    i_clr   = 1'b0;
    m_ovf   = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_count", 32'(o_count), 32'd0);
    check("reset_full",  32'(o_full),  32'd0);
    check("reset_ovf",   32'(o_overflow), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Single push, visible one edge later.
    step(1'b1, 8'h55, 1'b0, 1'b0);
    check("first_valid", 32'(o_valid), 32'd1);
    check("first_data",  32'(o_data),  32'h55);
    check("first_count", 32'(o_count), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Fill to full, then drain in order.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    check("fill_full",  32'(o_full),  32'd1);
    check("fill_count", 32'(o_count), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_valid", 32'(o_valid), 32'd0);

    // Full, push without pop: byte dropped, flag set; flush clears.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    check("drop_count", 32'(o_count), 32'(DEPTH));
    check("drop_ovf",   32'(o_overflow), 32'(exp_ovf()));
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_count", 32'(o_count), 32'd0);
    check("clr_ovf",   32'(o_overflow), 32'd0);

    // Full, push with pop the same cycle: accepted, count holds at DEPTH.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hBB, 1'b1, 1'b0);
    check("pushpop_count", 32'(o_count), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("pushpop_empty", 32'(o_valid), 32'd0);

    // Empty with valid and ready: push only.
    step(1'b1, 8'h3C, 1'b1, 1'b0);
    check("empty_pushpop", 32'(o_count), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Streaming through pointer wraps.
    for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush with a simultaneous push and pop.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    check("clr_override", 32'(o_count), 32'd0);

    // Asynchronous reset between edges discards stored bytes at once.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    @(negedge i_clk);
    #2;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_rst_n = 1'b0;
    exp_q.delete();
    m_ovf = 1'b0;
    #1;
    check("async_valid", 32'(o_valid), 32'd0);
    check("async_count", 32'(o_count), 32'd0);
    @(negedge i_clk);
    #1;
    i_rst_n = 1'b1;
    step(1'b1, 8'h77, 1'b0, 1'b0);
    check("post_rst_data",  32'(o_data),  32'h77);
    check("post_rst_count", 32'(o_count), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic with occasional flushes.
    last_in = 8'h00;
    for (int i = 0; i < 600; i++) begin
      last_in = 8'($urandom);
      step(1'(($urandom % 10) < 6), last_in, 1'(($urandom % 10) < 4),
           1'(($urandom % 60) == 0));
    end
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("final_empty", 32'(o_valid), 32'd0);

    @(negedge i_clk);
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_byte_fifo.md
RX_BYTE_FIFO -- requirements
Module: rx_byte_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of byte entries; SHALL be a power of two, 2..64.
REQ-002 Port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port i_data  input  8  received byte from the UART receiver; sampled only when i_valid=1.
REQ-005 Port i_valid  input  1  single-cycle strobe marking i_data valid; no backpressure toward the receiver.
REQ-006 Port i_clr  input  1  synchronous flush.
REQ-007 Port o_data  output  8  byte at FIFO head; meaningful only while o_valid=1.
REQ-008 Port o_valid  output  1  FIFO non-empty.
REQ-009 Port i_ready  input  1  consumer accepts the head byte this cycle.
REQ-010 Port o_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-011 Port o_full  output  1  occupancy equals DEPTH.
REQ-012 Port o_overflow  output  1  sticky lost-byte flag (see Configuration).

Function
REQ-013 Storage SHALL be a DEPTH x 8 register array with write pointer, read pointer ($clog2(DEPTH) bits, natural wrap DEPTH-1 -> 0) and occupancy counter.
REQ-014 o_valid SHALL equal (count != 0); o_full SHALL equal (count == DEPTH); both derived from registered state only.
REQ-015 o_data SHALL be the array entry at the read pointer, no added register stage (show-ahead head).
REQ-016 Pop SHALL occur when o_valid=1 and i_ready=1: read pointer +1, head byte removed.
REQ-017 Push SHALL occur when i_valid=1 and (count<DEPTH or pop occurs same cycle): i_data written at write pointer, write pointer +1.
REQ-018 Push-to-visible latency SHALL be one cycle: byte pushed on edge N is on o_data with o_valid=1 after edge N.
REQ-019 Count update: push only +1; pop only -1; push and pop together unchanged; neither unchanged.
REQ-020 Empty with i_valid=1 and i_ready=1 SHALL push only; ready is ignored while o_valid=0.
REQ-021 Full with i_valid=1 and pop same cycle SHALL accept the new byte; count stays DEPTH.
REQ-022 Full with i_valid=1 and no pop SHALL drop i_data; array, pointers and count unchanged.
REQ-023 i_clr=1 SHALL on that edge zero both pointers, count and o_overflow, overriding any push/pop the same cycle; array contents need not clear.
REQ-024 FIFO order SHALL be preserved across any number of pointer wraps.

Reset
REQ-025 i_rst_n=0 SHALL immediately, independent of i_clk, zero pointers, count and o_overflow, giving o_valid=0, o_full=0, o_count=0.
REQ-026 Array contents SHALL NOT be reset; o_data is don't-care while o_valid=0.
REQ-027 Reset asserted mid-operation SHALL discard all stored bytes; first push after release behaves as on an empty FIFO.

Configuration
REQ-028 Macro RX_FIFO_OVERFLOW_EN defined: o_overflow SHALL set on the edge of any drop per REQ-022 and hold until i_clr or reset.
REQ-029 Macro RX_FIFO_OVERFLOW_EN undefined: o_overflow SHALL be constant 0 and no flag register implemented; drop behaviour per REQ-022 unchanged.

Verification
REQ-030 Reset, push 0x55 with i_ready=0 -> next cycle o_valid=1, o_data=0x55, o_count=1.
REQ-031 DEPTH=8, push 0x00..0x07, i_ready=0 -> o_full=1, o_count=8; then hold i_ready=1 -> bytes out 0x00..0x07 in order, o_valid=0 after 8th.
REQ-032 Full, push 0xAA with i_ready=0 -> count stays 8, 0xAA never emerges, o_overflow=1 (macro defined) / 0 (undefined); i_clr -> count=0, o_overflow=0.
REQ-033 Full, push 0xBB with i_ready=1 same cycle -> 0x00 popped, count stays 8, 0xBB emerges last.
REQ-034 Continuous push every cycle with i_ready=1 for 20 bytes (pointer wrap) -> output sequence matches input exactly, count never exceeds 1.
REQ-035 Push 3 bytes, assert i_rst_n=0 between clock edges -> o_valid and o_count drop to 0 immediately, before the next edge.
